csm_lockmem: RTL and testbench

Parametrised shared memory for the CSM subsystem with N request ports and per-address hold/release locking. It generalises the two-port A/B shared memory to NPORTS ports with configurable data width and depth. It adds deterministic same-cycle arbitration, error codes and optional automatic lock expiry. Ports are driven by the CSM BFM/tester; responses are registered one cycle later.

---
 rtl/csm_lockmem.sv | 165 ++++++++++++++++
 tb/tb_csm_lockmem.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/csm_lockmem.sv
// rtl/csm_lockmem.sv - N-port shared memory with per-address hold/release locking
//
// Ports:
//   clk        : single clock, all state updates on the rising edge
//   reset      : asynchronous active-high reset, clears memory, locks and responses
//   req_valid  : per-port request strobe
//   req_op     : per-port op, 2 bits each (0 read, 1 write, 2 hold, 3 release)
//   req_addr   : per-port address, ADDR_W bits each
//   req_wdata  : per-port write data, DATA_W bits each
//   rsp_valid  : per-port response strobe, one cycle after the request
//   rsp_rdata  : per-port read data (0 unless a permitted read)
//   rsp_err    : per-port error (0 ok, 1 locked by other, 2 write collision, 3 bad release)
//   lock_map   : bit i set while address i is held
module csm_lockmem #(
    parameter int NPORTS       = 2,
    parameter int DATA_W       = 8,
    parameter int ADDR_W       = 3,
    parameter int HOLD_TIMEOUT = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NPORTS-1:0]        req_valid,
    input  logic [NPORTS*2-1:0]      req_op,
    input  logic [NPORTS*ADDR_W-1:0] req_addr,
    input  logic [NPORTS*DATA_W-1:0] req_wdata,
    output logic [NPORTS-1:0]        rsp_valid,
    output logic [NPORTS*DATA_W-1:0] rsp_rdata,
    output logic [NPORTS*2-1:0]      rsp_err,
    output logic [2**ADDR_W-1:0]     lock_map
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int OW    = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam int CW    = (HOLD_TIMEOUT > 0) ? $clog2(HOLD_TIMEOUT + 1) : 1;

    localparam logic [1:0] OP_READ    = 2'd0;
    localparam logic [1:0] OP_WRITE   = 2'd1;
    localparam logic [1:0] OP_HOLD    = 2'd2;
    localparam logic [1:0] OP_RELEASE = 2'd3;

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_LOCKED  = 2'd1;
    localparam logic [1:0] ERR_COLLIDE = 2'd2;
    localparam logic [1:0] ERR_RELEASE = 2'd3;

    logic [DATA_W-1:0] mem        [DEPTH];
    logic [DEPTH-1:0]  lock_valid;
    logic [OW-1:0]     lock_owner [DEPTH];
    logic [CW-1:0]     hold_cnt   [DEPTH];

    logic [DEPTH-1:0]         lv_n;
    logic [OW-1:0]            lo_n     [DEPTH];
    logic [CW-1:0]            cnt_n    [DEPTH];
    logic [DEPTH-1:0]         touched;
    logic [DEPTH-1:0]         wr_taken;
    logic [NPORTS-1:0]        wr_en;
    logic [NPORTS*DATA_W-1:0] rdata_n;
    logic [NPORTS*2-1:0]      err_n;
    logic [ADDR_W-1:0]        a;
    logic [1:0]               op;
    logic                     own_ok;

    // Ports are resolved in index order; lv_n/lo_n carry the lock effects of
    // lower-numbered ports forward so that higher ports see them.
    always_comb begin
        lv_n     = lock_valid;
        lo_n     = lock_owner;
        cnt_n    = hold_cnt;
        touched  = '0;
        wr_taken = '0;
        wr_en    = '0;
        rdata_n  = '0;
        err_n    = '0;
        a        = '0;
        op       = '0;
        own_ok   = 1'b0;
        for (int k = 0; k < NPORTS; k++) begin
            if (req_valid[k]) begin
                a      = req_addr[k*ADDR_W +: ADDR_W];
                op     = req_op[k*2 +: 2];
                own_ok = !lv_n[a] || (lo_n[a] == OW'(k));
                case (op)
                    OP_READ: begin
                        // Reads see start-of-cycle memory (read-before-write).
                        if (own_ok) rdata_n[k*DATA_W +: DATA_W] = mem[a];
                        else        err_n[k*2 +: 2] = ERR_LOCKED;
                    end
                    OP_WRITE: begin
                        if (!own_ok) begin
                            err_n[k*2 +: 2] = ERR_LOCKED;
                        end else if (wr_taken[a]) begin
                            err_n[k*2 +: 2] = ERR_COLLIDE;
                        end else begin
                            wr_taken[a] = 1'b1;
                            wr_en[k]    = 1'b1;
                        end
                    end
                    OP_HOLD: begin
                        if (own_ok) begin
                            lv_n[a]    = 1'b1;
                            lo_n[a]    = OW'(k);
                            touched[a] = 1'b1;
                        end else begin
                            err_n[k*2 +: 2] = ERR_LOCKED;
                        end
                    end
                    default: begin
                        if (lv_n[a] && (lo_n[a] == OW'(k))) begin
                            lv_n[a]    = 1'b0;
                            touched[a] = 1'b1;
                        end else begin
                            err_n[k*2 +: 2] = ERR_RELEASE;
                        end
                    end
                endcase
            end
        end
        // Expiry: an owner hold/release this cycle (touched) restarts or clears
        // the counter and so wins over expiry.
        for (int i = 0; i < DEPTH; i++) begin
            if (touched[i] || !lv_n[i]) begin
                cnt_n[i] = '0;
            end else if (HOLD_TIMEOUT > 0) begin
                if (hold_cnt[i] == CW'(HOLD_TIMEOUT - 1)) begin
                    lv_n[i]  = 1'b0;
                    cnt_n[i] = '0;
                end else begin
                    cnt_n[i] = hold_cnt[i] + CW'(1);
                end
            end else begin
                cnt_n[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i]        <= '0;
                lock_owner[i] <= '0;
                hold_cnt[i]   <= '0;
            end
            lock_valid <= '0;
            rsp_valid  <= '0;
            rsp_rdata  <= '0;
            rsp_err    <= '0;
        end else begin
            // At most one permitted writer per address, so these never overlap.
            for (int k = 0; k < NPORTS; k++) begin
                if (wr_en[k]) mem[req_addr[k*ADDR_W +: ADDR_W]] <= req_wdata[k*DATA_W +: DATA_W];
            end
            for (int i = 0; i < DEPTH; i++) begin
                lock_owner[i] <= lo_n[i];
                hold_cnt[i]   <= cnt_n[i];
            end
            lock_valid <= lv_n;
            rsp_valid  <= req_valid;
            rsp_rdata  <= rdata_n;
            rsp_err    <= err_n;
        end
    end

    assign lock_map = lock_valid;

endmodule

// File: tb/tb_csm_lockmem.sv
// tb/tb_csm_lockmem.sv - randomized and directed bench for csm_lockmem against a behavioural model
module tb_csm_lockmem;

    localparam int NP  = 3;
    localparam int DW  = 8;
    localparam int AW  = 3;
    localparam int DEP = 2 ** AW;
    localparam int TMO = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [NP-1:0]   req_valid = '0;
    logic [NP*2-1:0] req_op = '0;
    logic [NP*AW-1:0] req_addr = '0;
    logic [NP*DW-1:0] req_wdata = '0;
    logic [NP-1:0]   rsp_valid;
    logic [NP*DW-1:0] rsp_rdata;
    logic [NP*2-1:0] rsp_err;
    logic [DEP-1:0]  lock_map;

    csm_lockmem #(.NPORTS(NP), .DATA_W(DW), .ADDR_W(AW), .HOLD_TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .lock_map(lock_map)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Pending requests for the next cycle
    bit       r_valid [NP];
    int       r_op    [NP];
    int       r_addr  [NP];
    int       r_wdata [NP];

    // Model state: owner -1 means free, age counts cycles held since grant
    int m_mem [DEP];
    int m_own [DEP];
    int m_age [DEP];

    int e_valid [NP];
    int e_rdata [NP];
    int e_err   [NP];

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEP; i++) begin
            m_mem[i] = 0;
            m_own[i] = -1;
            m_age[i] = 0;
        end
    endtask

    task automatic model_step();
        int  old_mem [DEP];
        bit  touched [DEP];
        bit  wtaken  [DEP];
        int  a;
        bit  ok;
        old_mem = m_mem;
        for (int i = 0; i < DEP; i++) begin
            touched[i] = 0;
            wtaken[i]  = 0;
        end
        for (int p = 0; p < NP; p++) begin
            e_valid[p] = r_valid[p] ? 1 : 0;
            e_rdata[p] = 0;
            e_err[p]   = 0;
            if (!r_valid[p]) continue;
            a  = r_addr[p];
            ok = (m_own[a] < 0) || (m_own[a] == p);
            case (r_op[p])
                0: if (ok) e_rdata[p] = old_mem[a]; else e_err[p] = 1;
                1: begin
                    if (!ok) e_err[p] = 1;
                    else if (wtaken[a]) e_err[p] = 2;
                    else begin
                        wtaken[a] = 1;
                        m_mem[a]  = r_wdata[p];
                    end
                end
                2: begin
                    if (ok) begin
                        m_own[a] = p;
                        m_age[a] = 0;
                        touched[a] = 1;
                    end else e_err[p] = 1;
                end
                default: begin
                    if (m_own[a] == p) begin
                        m_own[a] = -1;
                        touched[a] = 1;
                    end else e_err[p] = 3;
                end
            endcase
        end
        for (int i = 0; i < DEP; i++) begin
            if (!touched[i] && m_own[i] >= 0) begin
                m_age[i]++;
                if (m_age[i] == TMO) m_own[i] = -1;
            end
        end
    endtask

    task automatic clr();
        for (int p = 0; p < NP; p++) begin
            r_valid[p] = 0;
            r_op[p]    = 0;
            r_addr[p]  = 0;
            r_wdata[p] = 0;
        end
    endtask

    task automatic set_req(input int p, input int op, input int addr, input int wd);
        r_valid[p] = 1;
        r_op[p]    = op;
        r_addr[p]  = addr;
        r_wdata[p] = wd;
    endtask

    // Drive current requests (called after a falling edge), run the model,
    // then compare after the following rising edge.
    task automatic cycle(input string tag);
        int exp_map;
        for (int p = 0; p < NP; p++) begin
            req_valid[p]          = r_valid[p];
            req_op[p*2 +: 2]      = 2'(r_op[p]);
            req_addr[p*AW +: AW]  = AW'(r_addr[p]);
            req_wdata[p*DW +: DW] = DW'(r_wdata[p]);
        end
        model_step();
        @(posedge clk);
        #1;
        for (int p = 0; p < NP; p++) begin
            check($sformatf("%s p%0d valid", tag, p), int'(rsp_valid[p]), e_valid[p]);
            check($sformatf("%s p%0d rdata", tag, p), int'(rsp_rdata[p*DW +: DW]), e_rdata[p]);
            check($sformatf("%s p%0d err", tag, p), int'(rsp_err[p*2 +: 2]), e_err[p]);
        end
        exp_map = 0;
        for (int i = 0; i < DEP; i++) if (m_own[i] >= 0) exp_map |= (1 << i);
        check($sformatf("%s lock_map", tag), int'(lock_map), exp_map);
        @(negedge clk);
        clr();
    endtask

    initial begin
        clr();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset rsp_valid", int'(rsp_valid), 0);
        check("reset rsp_rdata", int'(rsp_rdata), 0);
        check("reset rsp_err", int'(rsp_err), 0);
        check("reset lock_map", int'(lock_map), 0);
        @(negedge clk);
        reset = 1'b0;

        // Basic write then read, read of untouched address
        set_req(0, 1, 3, 8'hA5);                          cycle("wr3");
        set_req(1, 0, 3, 0); set_req(0, 0, 4, 0);         cycle("rd3");
        // Lock denial and release
        set_req(0, 2, 2, 0);                              cycle("hold2");
        set_req(1, 0, 2, 0);                              cycle("rd2_denied");
        set_req(1, 1, 2, 8'hFF);                          cycle("wr2_denied");
        set_req(0, 3, 2, 0);                              cycle("rel2");
        set_req(1, 0, 2, 0);                              cycle("rd2_ok");
        // Same-cycle hold race
        set_req(0, 2, 5, 0); set_req(1, 2, 5, 0);         cycle("hold5_race");
        set_req(1, 1, 5, 8'h77);                          cycle("wr5_owner0");
        set_req(0, 3, 5, 0);                              cycle("rel5");
        // Same-cycle write collision and read-before-write
        set_req(0, 1, 1, 8'h11); set_req(1, 1, 1, 8'h22); cycle("wr1_collide");
        set_req(1, 0, 1, 0);                              cycle("rd1");
        set_req(0, 1, 1, 8'h33); set_req(1, 0, 1, 0);     cycle("wr_rd1");
        set_req(2, 0, 1, 0);                              cycle("rd1_after");
        // Bad releases
        set_req(1, 3, 6, 0);                              cycle("rel6_unlocked");
        set_req(1, 2, 0, 0);                              cycle("hold0_p1");
        set_req(0, 3, 0, 0);                              cycle("rel0_nonowner");
        set_req(1, 3, 0, 0);                              cycle("rel0_owner");
        // Timeout expiry
        set_req(0, 2, 7, 0);                              cycle("hold7");
        for (int i = 0; i < TMO; i++) cycle($sformatf("idle%0d", i));
        set_req(1, 1, 7, 8'h5C);                          cycle("wr7_after");
        // Owner refresh in the expiry cycle keeps the lock
        set_req(2, 2, 6, 0);                              cycle("hold6");
        for (int i = 0; i < TMO - 1; i++) cycle($sformatf("wait6_%0d", i));
        set_req(2, 2, 6, 0);                              cycle("refresh6");
        set_req(0, 0, 6, 0);                              cycle("rd6_denied");

        // Async reset while locks are held and a response is outstanding
        set_req(0, 2, 4, 0);                              cycle("hold4");
        set_req(1, 0, 3, 0);
        for (int p = 0; p < NP; p++) req_valid[p] = r_valid[p];
        req_op[3:2] = 2'd0;
        req_addr[2*AW-1:AW] = AW'(3);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async reset rsp_valid", int'(rsp_valid), 0);
        check("async reset lock_map", int'(lock_map), 0);
        model_reset();
        clr();
        req_valid = '0;
        @(negedge clk);
        reset = 1'b0;
        set_req(0, 0, 3, 0); set_req(1, 0, 1, 0);         cycle("rd_after_reset");

        // Random traffic on a narrow address range to force conflicts
        for (int n = 0; n < 400; n++) begin
            for (int p = 0; p < NP; p++) begin
                if ($urandom_range(3) != 0)
                    set_req(p, int'($urandom_range(3)), int'($urandom_range(3)), int'($urandom_range(255)));
            end
            cycle($sformatf("rnd%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout got=1 exp=0");
        $fatal(1);
    end

endmodule
